// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter slice.
// Holds the frame state encoding, the parity-mode codes and a couple of
// small helpers used by the frame FSM.
// No ports; imported by uart_transmitter.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  // Mode 2'b11 is reserved and behaves like "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

  // acc is the running XOR of the data bits already sent.
  function automatic logic parity_bit(input logic [1:0] mode, input logic acc);
    return (mode == PARITY_ODD) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Word FIFO feeding the UART transmitter.
// Wrap-around read/write pointers plus an occupancy count; DEPTH must be a
// power of two so the pointers wrap for free.
// Ports:
//   clk, rst        system clock, async active-high reset (empties the FIFO)
//   push, wdata     write request and word; ignored while full
//   pop             read request; ignored while empty
//   rdata           current head word (valid while !empty)
//   full, empty     occupancy flags derived from the registered count
//   count           words held
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Parametrised UART transmitter with a word FIFO.
// Serialises start / data (LSB first) / optional parity / stop / optional
// gap bits, advancing one bit per baud_tick while en is high.
// Ports:
//   clk, rst     system clock, async active-high reset
//   en           block enable; low aborts the current frame
//   baud_tick    one-clk pulse per bit period
//   parity_mode  00 none, 01 even, 10 odd, 11 none; latched at frame start
//   in_data, in_valid, in_ready   word push interface (in_ready = !full)
//   fifo_count   words waiting in the FIFO
//   busy         a frame is on the line
//   done         one-clk pulse on the tick that closes a frame
//   out          serial line, idle high
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          baud_tick,
  input  logic [1:0]                    parity_mode,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          done,
  output logic                          out
);

  localparam int MAX_DS  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int MAX_CNT = (MAX_DS > GAP_BITS) ? MAX_DS : GAP_BITS;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_acc_q, par_acc_d;
  logic [1:0]             par_mode_q, par_mode_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   frame_end, frame_start;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Frame FSM. Each case arm decides what the line carries for the next bit
  // period; starting a frame is shared between IDLE and the end-of-frame
  // tick so back-to-back frames need no idle bit.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_acc_d   = par_acc_q;
    par_mode_d  = par_mode_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;
    frame_end   = 1'b0;
    frame_start = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      out_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) frame_start = 1'b1;
        end
        ST_START: begin
          out_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          par_acc_d = par_acc_q ^ shift_q[0];
          cnt_d     = CNT_W'(1);
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(DATA_BITS)) begin
            cnt_d = CNT_W'(1);
            if (parity_enabled(par_mode_q)) begin
              out_d   = parity_bit(par_mode_q, par_acc_q);
              state_d = ST_PARITY;
            end else begin
              out_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            out_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            par_acc_d = par_acc_q ^ shift_q[0];
            cnt_d     = cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          out_d   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (cnt_q == CNT_W'(STOP_BITS)) begin
            if (GAP_BITS > 0) begin
              out_d   = 1'b1;
              cnt_d   = CNT_W'(1);
              state_d = ST_GAP;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_BITS)) frame_end = 1'b1;
          else                           cnt_d = cnt_q + 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase

      if (frame_end) begin
        done_d = 1'b1;
        if (!fifo_empty) begin
          frame_start = 1'b1;
        end else begin
          state_d = ST_IDLE;
          out_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end

      // Pop the head word and put the start bit on the line this tick.
      if (frame_start) begin
        fifo_pop   = 1'b1;
        shift_d    = fifo_rdata;
        par_mode_d = parity_mode;
        par_acc_d  = 1'b0;
        cnt_d      = '0;
        out_d      = 1'b0;
        busy_d     = 1'b1;
        state_d    = ST_START;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_acc_q  <= 1'b0;
      par_mode_q <= PARITY_NONE;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_acc_q  <= par_acc_d;
      par_mode_q <= par_mode_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter.
// Two instances share clock, reset, enable and baud tick:
//   A: 8 data bits, 1 stop bit, no gap
//   B: 7 data bits, 2 stop bits, 1 gap bit
// Expected line bits are queued per instance when words are pushed and
// compared on every baud tick; done is expected on the tick after the
// last bit of each frame.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       baud_tick;
  logic [1:0] parity_mode;

  logic [7:0] in_data_a;
  logic       in_valid_a, in_ready_a, busy_a, done_a, out_a;
  logic [2:0] fifo_count_a;

  logic [6:0] in_data_b;
  logic       in_valid_b, in_ready_b, busy_b, done_b, out_b;
  logic [2:0] fifo_count_b;

  uart_transmitter #(.DATA_BITS(8), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .baud_tick(baud_tick), .parity_mode(parity_mode),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .fifo_count(fifo_count_a), .busy(busy_a), .done(done_a), .out(out_a)
  );

  uart_transmitter #(.DATA_BITS(7), .STOP_BITS(2), .GAP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .baud_tick(baud_tick), .parity_mode(parity_mode),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .fifo_count(fifo_count_b), .busy(busy_b), .done(done_b), .out(out_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } sb_item_t;

  typedef struct {
    int         sel;
    logic [1:0] pmode;
    logic [8:0] data;
    int         len;
    logic [15:0] bits;   // frame bits in time order, first bit at bits[len-1]
    int         period;
    bit         last;
  } vec_t;

  sb_item_t q_a[$];
  sb_item_t q_b[$];
  logic     pend_done [2];
  int       done_cnt [2];
  int       n_pass = 0;
  int       n_checks = 0;
  int       tick_period = 0;
  bit       mon_on = 1'b0;
  logic     tick_prev = 1'b0;
  vec_t     vecs [11];

  // Baud generator: 0 = stalled, 1 = held high, N = one pulse every N clks.
  initial begin
    int cnt;
    cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_period == 0) begin
        baud_tick = 1'b0;
        cnt = 0;
      end else if (tick_period == 1) begin
        baud_tick = 1'b1;
      end else begin
        baud_tick = (cnt == tick_period - 1);
        cnt = (cnt + 1) % tick_period;
      end
    end
  end

  always @(posedge clk) tick_prev = baud_tick && en;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pushBit(input int sel, input logic b, input logic last);
    sb_item_t it;
    it.b = b;
    it.last = last;
    if (sel == 0) q_a.push_back(it);
    else          q_b.push_back(it);
  endtask

  task automatic sbPushBits(input int sel, input int len, input logic [15:0] bits);
    for (int i = 0; i < len; i++) pushBit(sel, bits[len-1-i], (i == len - 1));
  endtask

  // Reference frame builder for the hand-written sequences.
  task automatic sbPushWord(input int sel, input logic [8:0] data, input logic [1:0] pmode);
    int db, nb, total, k;
    logic par;
    logic [15:0] bits;
    db = (sel == 0) ? 8 : 7;
    nb = (sel == 0) ? 1 : 3;
    par = 1'b0;
    total = 1 + db + nb + ((pmode == 2'b01 || pmode == 2'b10) ? 1 : 0);
    bits = '0;
    k = total - 1;
    bits[k] = 1'b0; k--;
    for (int i = 0; i < db; i++) begin
      bits[k] = data[i];
      par = par ^ data[i];
      k--;
    end
    if (pmode == 2'b01)      begin bits[k] = par;  k--; end
    else if (pmode == 2'b10) begin bits[k] = ~par; k--; end
    for (int i = 0; i < nb; i++) begin bits[k] = 1'b1; k--; end
    sbPushBits(sel, total, bits);
  endtask

  task automatic monitorTick(input int d, input logic o, input logic b, input logic dn);
    sb_item_t it;
    logic have;
    string p;
    p = (d == 0) ? "A" : "B";
    checkOutput({p, ".done"}, dn, pend_done[d]);
    pend_done[d] = 1'b0;
    have = 1'b0;
    if (d == 0 && q_a.size() > 0) begin it = q_a.pop_front(); have = 1'b1; end
    if (d == 1 && q_b.size() > 0) begin it = q_b.pop_front(); have = 1'b1; end
    if (have) begin
      checkOutput({p, ".busy"}, b, 1'b1);
      checkOutput({p, ".out"}, o, it.b);
      if (it.last) pend_done[d] = 1'b1;
    end else begin
      checkOutput({p, ".busy_idle"}, b, 1'b0);
      checkOutput({p, ".out_idle"}, o, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (tick_prev) begin
        monitorTick(0, out_a, busy_a, done_a);
        monitorTick(1, out_b, busy_b, done_b);
      end else begin
        checkOutput("A.done_between_ticks", done_a, 1'b0);
        checkOutput("B.done_between_ticks", done_b, 1'b0);
      end
      if (done_a) done_cnt[0]++;
      if (done_b) done_cnt[1]++;
    end
  end

  task automatic pushWord(input int sel, input logic [8:0] data);
    @(negedge clk);
    if (sel == 0) begin in_data_a = data[7:0]; in_valid_a = 1'b1; end
    else          begin in_data_b = data[6:0]; in_valid_b = 1'b1; end
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    logic drained;
    drained = 1'b0;
    for (int c = 0; c < 3000 && !drained; c++) begin
      @(negedge clk);
      drained = (q_a.size() == 0) && (q_b.size() == 0) && !pend_done[0] && !pend_done[1];
    end
    checkOutput(name, drained, 1'b1);
  endtask

  task automatic flushScoreboard();
    q_a.delete();
    q_b.delete();
    pend_done[0] = 1'b0;
    pend_done[1] = 1'b0;
  endtask

  task automatic waitTicks(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < 400 && seen < n; c++) begin
      @(negedge clk);
      if (tick_prev) seen++;
    end
  endtask

  // Runs every table burst: words pushed with the line stalled, then the
  // baud tick released and the frames drained through the scoreboard.
  task automatic applyStimulus();
    int frames;
    bit first;
    first = 1'b1;
    frames = 0;
    for (int i = 0; i < 11; i++) begin
      if (first) begin
        tick_period = 0;
        parity_mode = vecs[i].pmode;
        repeat (2) @(negedge clk);
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        frames = 0;
        first = 1'b0;
      end
      pushWord(vecs[i].sel, vecs[i].data);
      sbPushBits(vecs[i].sel, vecs[i].len, vecs[i].bits);
      frames++;
      if (vecs[i].last) begin
        tick_period = vecs[i].period;
        waitDrain($sformatf("drain_vec%0d", i));
        checkOutput($sformatf("done_count_vec%0d", i), 16'(done_cnt[vecs[i].sel]), 16'(frames));
        tick_period = 0;
        first = 1'b1;
      end
    end
  endtask

  initial begin
    int seen;
    logic [8:0] words [5];

    //          sel pm     data    len bits (time order)          period last
    vecs[0]  = '{0, 2'b00, 9'h0A5, 10, 16'b0101001011,     16, 1'b1};
    vecs[1]  = '{1, 2'b01, 9'h053, 12, 16'b011001010111,    8, 1'b1};
    vecs[2]  = '{1, 2'b10, 9'h053, 12, 16'b011001011111,    8, 1'b1};
    vecs[3]  = '{0, 2'b00, 9'h000, 10, 16'b0000000001,      4, 1'b0};
    vecs[4]  = '{0, 2'b00, 9'h0FF, 10, 16'b0111111111,      4, 1'b0};
    vecs[5]  = '{0, 2'b00, 9'h03C, 10, 16'b0001111001,      4, 1'b1};
    vecs[6]  = '{1, 2'b00, 9'h000, 11, 16'b00000000111,     1, 1'b0};
    vecs[7]  = '{1, 2'b00, 9'h07F, 11, 16'b01111111111,     1, 1'b0};
    vecs[8]  = '{1, 2'b00, 9'h03C, 11, 16'b00011110111,     1, 1'b1};
    vecs[9]  = '{0, 2'b01, 9'h0A5, 11, 16'b01010010101,     1, 1'b1};
    vecs[10] = '{0, 2'b11, 9'h03C, 10, 16'b0001111001,      3, 1'b1};

    rst = 1'b1;
    en = 1'b1;
    parity_mode = 2'b00;
    in_data_a = '0; in_valid_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0;
    pend_done[0] = 1'b0; pend_done[1] = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst.out", out_a, 1'b1);
    checkOutput("rst.busy", busy_a, 1'b0);
    checkOutput("rst.done", done_a, 1'b0);
    checkOutput("rst.in_ready", in_ready_a, 1'b1);
    checkOutput("rst.fifo_count", fifo_count_a, 3'd0);
    checkOutput("rst.B.out", out_b, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    applyStimulus();

    // FIFO fill with the line stalled; the fifth word must be refused.
    tick_period = 0;
    parity_mode = 2'b00;
    repeat (2) @(negedge clk);
    words[0] = 9'h0A5; words[1] = 9'h000; words[2] = 9'h0FF;
    words[3] = 9'h03C; words[4] = 9'h05A;
    for (int k = 0; k < 5; k++) begin
      pushWord(0, words[k]);
      checkOutput($sformatf("fifo_count_push%0d", k + 1), fifo_count_a, (k < 4) ? 3'(k + 1) : 3'd4);
      checkOutput($sformatf("in_ready_push%0d", k + 1), in_ready_a, (k < 3) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 4; k++) sbPushWord(0, words[k], 2'b00);
    done_cnt[0] = 0;
    tick_period = 16;
    waitTicks(1, seen);
    checkOutput("fifo_first_tick_seen", 16'(seen), 16'd1);
    checkOutput("fifo_in_ready_after_pop", in_ready_a, 1'b1);
    checkOutput("fifo_count_after_pop", fifo_count_a, 3'd3);
    waitDrain("drain_fifo");
    checkOutput("fifo_done_count", 16'(done_cnt[0]), 16'd4);

    // Enable abort during the third data bit of 0xA5.
    tick_period = 0;
    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    flushScoreboard();
    pushWord(0, 9'h0A5);
    pushWord(0, 9'h03C);
    tick_period = 4;
    waitTicks(3, seen);
    checkOutput("abort_data_bit1", out_a, 1'b0);
    waitTicks(1, seen);
    checkOutput("abort_data_bit2", out_a, 1'b1);
    checkOutput("abort_busy_before", busy_a, 1'b1);
    en = 1'b0;
    @(negedge clk);
    checkOutput("abort_out", out_a, 1'b1);
    checkOutput("abort_busy", busy_a, 1'b0);
    checkOutput("abort_done", done_a, 1'b0);
    checkOutput("abort_fifo_kept", fifo_count_a, 3'd1);
    repeat (6) @(negedge clk);
    checkOutput("abort_done_held_low", done_a, 1'b0);
    checkOutput("abort_out_held_high", out_a, 1'b1);
    done_cnt[0] = 0;
    sbPushWord(0, 9'h03C, 2'b00);
    en = 1'b1;
    mon_on = 1'b1;
    waitDrain("drain_after_abort");
    checkOutput("abort_resume_done_count", 16'(done_cnt[0]), 16'd1);

    // Asynchronous reset in the middle of a frame.
    tick_period = 0;
    repeat (2) @(negedge clk);
    pushWord(0, 9'h0A5);
    pushWord(0, 9'h03C);
    sbPushWord(0, 9'h0A5, 2'b00);
    sbPushWord(0, 9'h03C, 2'b00);
    tick_period = 8;
    waitTicks(3, seen);
    checkOutput("rst_mid_fifo_before", fifo_count_a, 3'd1);
    mon_on = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out", out_a, 1'b1);
    checkOutput("rst_mid_busy", busy_a, 1'b0);
    checkOutput("rst_mid_fifo_count", fifo_count_a, 3'd0);
    checkOutput("rst_mid_in_ready", in_ready_a, 1'b1);
    flushScoreboard();
    @(negedge clk);
    rst = 1'b0;
    tick_period = 2;
    mon_on = 1'b1;
    repeat (12) @(negedge clk);
    mon_on = 1'b0;
    tick_period = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
